// File: rtl/video_timing_ctrl.sv
// Raster timing generator: pixel/line counters, registered syncs and de.
// Stopping always completes the current frame before returning to idle.
module video_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pclk_ena,
  input  logic        enable,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] hcnt,
  output logic [11:0] vcnt,
  output logic        line_start,
  output logic        frame_start,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
  localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state;

  logic        h_wrap;
  logic        v_wrap;
  logic        stop;
  logic [11:0] h_nxt;
  logic [11:0] v_nxt;
  logic        de_nxt;
  logic        hs_nxt;
  logic        vs_nxt;

  always_comb begin
    h_wrap = (hcnt == H_LAST);
    v_wrap = (vcnt == V_LAST);
    stop   = (state == DRAIN) && !enable && h_wrap && v_wrap;
    h_nxt  = '0;
    v_nxt  = '0;
    if (state != IDLE && !stop) begin
      h_nxt = h_wrap ? 12'd0 : hcnt + 12'd1;
      v_nxt = !h_wrap ? vcnt : (v_wrap ? 12'd0 : vcnt + 12'd1);
    end
    de_nxt = ({1'b0, h_nxt} < H_ACT) && ({1'b0, v_nxt} < V_ACT);
    hs_nxt = ({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END);
    vs_nxt = ({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hcnt        <= '0;
      vcnt        <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pclk_ena) begin
        unique case (state)
          IDLE: begin
            if (enable) begin
              state       <= RUN;
              hcnt        <= '0;
              vcnt        <= '0;
              de          <= de_nxt;
              hsync       <= hs_nxt ? HS_POL : ~HS_POL;
              vsync       <= vs_nxt ? VS_POL : ~VS_POL;
              line_start  <= 1'b1;
              frame_start <= 1'b1;
            end
          end
          RUN, DRAIN: begin
            // the final pixel of a drained frame lands in idle silently
            if (stop) begin
              state <= IDLE;
              hcnt  <= '0;
              vcnt  <= '0;
              de    <= 1'b0;
              hsync <= ~HS_POL;
              vsync <= ~VS_POL;
            end else begin
              state       <= enable ? RUN : DRAIN;
              hcnt        <= h_nxt;
              vcnt        <= v_nxt;
              de          <= de_nxt;
              hsync       <= hs_nxt ? HS_POL : ~HS_POL;
              vsync       <= vs_nxt ? VS_POL : ~VS_POL;
              line_start  <= (h_nxt == 12'd0);
              frame_start <= (h_nxt == 12'd0) && (v_nxt == 12'd0);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl on an 8x6 raster with a
// reference model feeding an expected-output queue.
module tb_video_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pclk_ena;
  logic        enable;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [11:0] hcnt;
  logic [11:0] vcnt;
  logic        line_start;
  logic        frame_start;
  logic        busy;

  video_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pclk_ena(pclk_ena), .enable(enable),
    .hsync(hsync), .vsync(vsync), .de(de), .hcnt(hcnt), .vcnt(vcnt),
    .line_start(line_start), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        de;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic        busy;
  } obs_t;

  obs_t q[$];

  int checks = 0;
  int errors = 0;

  int mst = 0;
  int mh  = 0;
  int mv  = 0;

  int pe_cnt  = 0;
  int last_ls = -1;
  int last_fs = -1;
  int fs_cnt  = 0;
  int busy_lo = 0;

  function automatic obs_t dut_obs();
    return '{hcnt, vcnt, de, hsync, vsync, line_start, frame_start, busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_reset(input string tag);
    obs_t r;
    r = '{12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    chk(tag, 32'(dut_obs()), 32'(r));
  endtask

  task automatic tick(input logic pe);
    obs_t e;
    obs_t o;
    logic ls;
    logic fs;
    ls = 1'b0;
    fs = 1'b0;
    @(negedge clk);
    pclk_ena = pe;
    if (!rst_n) begin
      mst = 0; mh = 0; mv = 0;
    end else if (pe) begin
      if (mst == 0) begin
        if (enable) begin
          mst = 1; mh = 0; mv = 0; ls = 1'b1; fs = 1'b1;
        end
      end else if (mst == 2 && !enable && mh == 7 && mv == 5) begin
        mst = 0; mh = 0; mv = 0;
      end else begin
        if (mh == 7) begin
          mh = 0;
          mv = (mv == 5) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
        mst = enable ? 1 : 2;
        ls = (mh == 0);
        fs = (mh == 0) && (mv == 0);
      end
    end
    e.h    = 12'(mh);
    e.v    = 12'(mv);
    e.de   = (mst != 0) && (mh < 4) && (mv < 3);
    e.hs   = !((mst != 0) && mh >= 5 && mh < 7);
    e.vs   = !((mst != 0) && mv == 4);
    e.ls   = ls;
    e.fs   = fs;
    e.busy = (mst != 0);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    o = dut_obs();
    chk($sformatf("outputs pe=%0b @(%0d,%0d)", pe, mv, mh),
        32'(o), 32'(e));
    if (pe) begin
      pe_cnt++;
      if (line_start === 1'b1) begin
        if (last_ls >= 0) chk("line_period", 32'(pe_cnt - last_ls), 32'd8);
        last_ls = pe_cnt;
      end
      if (frame_start === 1'b1) begin
        fs_cnt++;
        if (last_fs >= 0) chk("frame_period", 32'(pe_cnt - last_fs), 32'd48);
        last_fs = pe_cnt;
      end
    end
    if (busy !== 1'b1) busy_lo++;
    if (mst == 0) begin
      last_ls = -1;
      last_fs = -1;
    end
  endtask

  task automatic pedge();
    tick(1'b1);
    tick(1'b0);
  endtask

  task automatic run_to(input int v, input int h);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mh == h && mv == v && mst != 0) begin
        found = 1'b1;
        break;
      end
      pedge();
    end
    chk($sformatf("run_to(%0d,%0d)", v, h), 32'(found), 32'd1);
  endtask

  task automatic run_idle();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mst == 0) begin
        found = 1'b1;
        break;
      end
      pedge();
    end
    chk("drain_to_idle", 32'(found), 32'd1);
  endtask

  int save_h;
  int save_v;

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    pclk_ena = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_state");
    rst_n = 1'b1;

    repeat (3) pedge();
    chk("idle_busy", 32'(busy), 32'd0);

    enable = 1'b1;
    tick(1'b0);
    chk("deferred_start", 32'(busy), 32'd0);
    tick(1'b1);
    chk("first_fs", 32'(frame_start), 32'd1);
    chk("first_pos", 32'({vcnt, hcnt}), 32'd0);
    tick(1'b0);

    fs_cnt = 0;
    for (int i = 0; i < 48; i++) pedge();
    chk("frame_count", 32'(fs_cnt), 32'd1);
    chk("frame_wrap_pos", 32'({vcnt, hcnt}), 32'd0);

    run_to(1, 0);
    enable  = 1'b0;
    fs_cnt  = 0;
    busy_lo = 0;
    run_to(5, 7);
    chk("drain_busy_low", 32'(busy_lo), 32'd0);
    pedge();
    chk("drain_idle_busy", 32'(busy), 32'd0);
    chk("drain_idle_pos", 32'({vcnt, hcnt}), 32'd0);
    chk("drain_no_fs", 32'(fs_cnt), 32'd0);

    enable = 1'b1;
    pedge();
    run_to(2, 0);
    enable  = 1'b0;
    fs_cnt  = 0;
    busy_lo = 0;
    repeat (10) pedge();
    enable = 1'b1;
    run_to(5, 7);
    chk("redrain_busy_low", 32'(busy_lo), 32'd0);
    chk("redrain_no_fs", 32'(fs_cnt), 32'd0);
    pedge();
    chk("redrain_wrap_fs", 32'(fs_cnt), 32'd1);

    run_to(1, 2);
    save_h = mh;
    save_v = mv;
    repeat (10) tick(1'b0);
    chk("freeze_pos", 32'({vcnt, hcnt}), 32'({12'(save_v), 12'(save_h)}));
    chk("freeze_ls", 32'(line_start), 32'd0);
    pedge();

    run_to(2, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    tick(1'b1);
    chk_reset("reset_held");
    rst_n = 1'b1;
    tick(1'b1);
    chk("restart_fs", 32'(frame_start), 32'd1);
    chk("restart_pos", 32'({vcnt, hcnt}), 32'd0);
    repeat (4) pedge();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_ctrl.md
VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-006 The block SHALL have parameters V_FP, V_SYNC and V_BP, defaults 10, 2 and 33, vertical porch and sync widths in lines.
REQ-007 The block SHALL have parameters HS_POL and VS_POL, default 0 each, giving the asserted level of hsync and vsync.
REQ-008 The block SHALL have port clk, input, 1 bit, system clock.
REQ-009 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-010 The block SHALL have port pclk_ena, input, 1 bit, pixel-advance qualifier sampled on clk.
REQ-011 The block SHALL have port enable, input, 1 bit, level request to run timing.
REQ-012 The block SHALL have ports hsync, vsync and de, each an output of 1 bit, carrying the sync outputs and data enable.
REQ-013 The block SHALL have ports hcnt and vcnt, each an output of 12 bits, giving the current pixel and line position.
REQ-014 The block SHALL have ports line_start and frame_start, each an output of 1 bit, as single-clk pulses.
REQ-015 The block SHALL have port busy, output, 1 bit, high when the state is not IDLE.

Function
REQ-016 The timing totals SHALL be H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, each no greater than 4096; larger values are a configuration error.
REQ-017 The counters SHALL advance only on clk edges where pclk_ena=1; with pclk_ena=0, all outputs hold, except that line_start and frame_start return to 0.
REQ-018 Line order SHALL be active, then FP, then sync, then BP; the same order SHALL apply to frame lines.
REQ-019 hcnt SHALL count 0..H_TOTAL-1 and then wrap to 0; on each wrap vcnt SHALL increment, and it SHALL wrap from V_TOTAL-1 to 0.
REQ-020 de SHALL be 1 exactly when (hcnt < H_ACTIVE && vcnt < V_ACTIVE) and the state is not IDLE.
REQ-021 hsync SHALL be at HS_POL exactly when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, and at ~HS_POL otherwise.
REQ-022 vsync SHALL be at VS_POL exactly when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, and at ~VS_POL otherwise.
REQ-023 hsync, vsync, de, hcnt and vcnt SHALL be registered and SHALL update on the same clk edge, with zero skew between them.
REQ-024 line_start SHALL be a 1-clk pulse on each edge where hcnt becomes 0 in RUN or DRAIN; frame_start SHALL pulse when (hcnt,vcnt) becomes (0,0).
REQ-025 The FSM SHALL have the states IDLE, RUN and DRAIN.
REQ-026 In IDLE with enable=1 and pclk_ena=1, the FSM SHALL go to RUN with hcnt=vcnt=0 and pulse frame_start and line_start.
REQ-027 In RUN with enable=0, the FSM SHALL go to DRAIN on the same edge and keep the counters advancing.
REQ-028 In DRAIN with enable=1, the FSM SHALL return to RUN with no counter discontinuity and no extra frame_start.
REQ-029 In DRAIN on a pclk_ena edge at hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1, the FSM SHALL go to IDLE, clear the counters to 0 and emit no pulses; frames are never truncated.
REQ-030 In IDLE, de SHALL be 0, sync outputs SHALL be inactive and the counters SHALL be 0.
REQ-031 When enable rises on a cycle with pclk_ena=0, the start SHALL be deferred to the next cycle with pclk_ena=1.

Reset
REQ-032 Asserting rst_n=0 SHALL immediately force state=IDLE, hcnt=vcnt=0, de=0, hsync=~HS_POL, vsync=~VS_POL, line_start=frame_start=0 and busy=0, including mid-frame.
REQ-033 After reset release, the block SHALL stay in IDLE until REQ-026 is met.

Verification
Parameters for all scenarios: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), pclk_ena toggling every clk.
REQ-034 The bench SHALL cover: enable=1 after reset -> on the first pclk_ena edge frame_start=1 with hcnt=0 and vcnt=0; de high for hcnt 0..3 on vcnt 0..2; hsync=0 at hcnt 5..6.
REQ-035 The bench SHALL cover: a full frame -> vsync=0 only while vcnt=4; frame_start again after 48 pclk_ena edges; line_start every 8 edges.
REQ-036 The bench SHALL cover: enable dropped at vcnt=1 -> busy stays 1 through vcnt=5,hcnt=7, then IDLE with counters 0 and no frame_start.
REQ-037 The bench SHALL cover: enable dropped and re-raised during DRAIN -> counters continuous, busy never 0, and no extra frame_start.
REQ-038 The bench SHALL cover: pclk_ena held 0 for 10 clk mid-line -> all outputs frozen and pulses 0.
REQ-039 The bench SHALL cover: rst_n pulsed low at vcnt=2,hcnt=3 -> outputs reach reset values asynchronously, then restart at (0,0).
